// File: rtl/dist_ram_scheduler.sv
// dist_ram_scheduler: per-frame address-order scan of one async-read table RAM, sharing its single port with config writes.
// Optional feature macro DRS_STARVE_GUARD_EN: a write blocked for MAX_WAIT cycles is forced through for one cycle.
module dist_ram_scheduler #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 64,
    parameter int MAX_WAIT = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic             scan_busy,
    output logic             scan_done,
    output logic             overrun,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic          ptr_at_end;
    logic          can_load;
    logic          scan_issue;
    logic          force_wr;
    logic          wr_fire;

    // Handshakes: a beat transfers on a rising edge where valid && ready; valid never waits on ready,
    // and a producer holding valid keeps its payload stable until the transfer.
    assign ptr_at_end = (ptr == AW'(DEPTH - 1));
    assign can_load   = !rd_valid || rd_ready;
    assign scan_issue = (state == SCAN) && can_load && !force_wr;
    assign wr_ready   = !scan_issue;
    assign wr_fire    = wr_valid && wr_ready;
    assign ram_we     = wr_fire;
    assign ram_addr   = wr_fire ? wr_addr : ptr;
    assign ram_din    = wr_data;
    assign scan_busy  = (state == SCAN);
    assign scan_done  = rd_valid && rd_ready && rd_last;

`ifdef DRS_STARVE_GUARD_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);
    logic [WCW-1:0] wait_cnt;

    assign force_wr = (wait_cnt >= WCW'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!wr_valid || wr_fire) begin
            wait_cnt <= '0;
        end else if (!force_wr) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // Async-read RAM: data for ptr is on ram_dout during the issue cycle itself.
            if (scan_issue) begin
                rd_valid <= 1'b1;
                rd_addr  <= ptr;
                rd_data  <= ram_dout;
                rd_last  <= ptr_at_end;
                ptr      <= ptr + AW'(1);
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= SCAN;
                        ptr   <= '0;
                    end
                end
                SCAN: begin
                    if (frame_start) begin
                        overrun <= 1'b1;
                    end
                    if (scan_issue && ptr_at_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dist_ram_scheduler.sv
// tb_dist_ram_scheduler: directed bench for dist_ram_scheduler with a behavioural async-read table RAM.
module tb_dist_ram_scheduler;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 64;
    localparam int MAX_WAIT = 8;
    localparam int AW       = 6;

    logic             clk;
    logic             rst_n;
    logic             frame_start;
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    logic             scan_busy;
    logic             scan_done;
    logic             overrun;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_dout;

    logic [WIDTH-1:0] mem       [DEPTH];
    logic [WIDTH-1:0] exp_mem   [DEPTH];
    logic [WIDTH-1:0] frame_exp [DEPTH];

    int checks   = 0;
    int failures = 0;

    dist_ram_scheduler #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .overrun    (overrun),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // Clock / reset and RAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // mode 0: rd_ready=1, exact timing; 1: rd_ready toggling, write held; 2: writes to 40/3 at beat 10;
    // 3: frame_start at beat 20; 4: reset at beat 30; 5: write held with rd_ready=1 (starvation).
    task automatic run_scan(input int mode);
        int beat;
        int grants;
        beat   = 0;
        grants = 0;
        for (int i = 0; i < DEPTH; i++) frame_exp[i] = exp_mem[i];
        @(negedge clk);
        frame_start = 1'b1;
        rd_ready    = 1'b1;
        wr_valid    = 1'b0;
        if (mode == 0) begin
            wr_valid = 1'b1;
            wr_addr  = 6'd7;
            wr_data  = exp_mem[7];
        end
        #1;
        if (mode == 0) begin
            check("fs_wr_ready", 32'(wr_ready), 32'd1);
            check("fs_ram_we", 32'(ram_we), 32'd1);
        end
        for (int cyc = 0; cyc < 400 && beat < DEPTH; cyc++) begin
            @(negedge clk);
            frame_start = 1'b0;
            wr_valid    = 1'b0;
            rd_ready    = 1'b1;
            case (mode)
                1: begin
                    rd_ready = cyc[0];
                    wr_valid = 1'b1;
                    wr_addr  = 6'd2;
                    wr_data  = exp_mem[2];
                end
                2: begin
                    if (cyc == 11) begin
                        rd_ready = 1'b0;
                        wr_valid = 1'b1;
                        wr_addr  = 6'd40;
                        wr_data  = 16'h1234;
                        exp_mem[40]   = 16'h1234;
                        frame_exp[40] = 16'h1234;
                    end else if (cyc == 12) begin
                        rd_ready = 1'b0;
                        wr_valid = 1'b1;
                        wr_addr  = 6'd3;
                        wr_data  = 16'h3333;
                        exp_mem[3] = 16'h3333;
                    end
                end
                3: if (cyc == 21) frame_start = 1'b1;
                4: if (cyc == 31) rst_n = 1'b0;
                5: begin
                    wr_valid = 1'b1;
                    wr_addr  = 6'd2;
                    wr_data  = exp_mem[2];
                end
                default: ;
            endcase
            #1;
            // Scoreboard on accepted beats
            if (rd_valid && rd_ready) begin
                check("beat_addr", 32'(rd_addr), 32'(beat));
                check("beat_data", 32'(rd_data), 32'(frame_exp[beat]));
                check("beat_last", 32'(rd_last), 32'(beat == DEPTH - 1));
                check("beat_done", 32'(scan_done), 32'(beat == DEPTH - 1));
                beat++;
            end else begin
                check("no_done", 32'(scan_done), 32'd0);
            end
            if (mode == 0) begin
                check("valid_run", 32'(rd_valid), 32'(cyc >= 1));
                check("busy_run", 32'(scan_busy), 32'(cyc < DEPTH));
            end
            if (mode == 1 && scan_busy) begin
                check("stall_only_grant", 32'(wr_ready), 32'(rd_valid && !rd_ready));
                if (wr_ready) grants++;
            end
            if (mode == 2 && (cyc == 11 || cyc == 12)) begin
                check("mid_pos_valid", 32'(rd_valid), 32'd1);
                check("mid_pos_addr", 32'(rd_addr), 32'd10);
                check("mid_wr_ready", 32'(wr_ready), 32'd1);
                check("mid_ram_addr", 32'(ram_addr), (cyc == 11) ? 32'd40 : 32'd3);
            end
            if (mode == 5 && scan_busy) begin
`ifdef DRS_STARVE_GUARD_EN
                check("guard_grant", 32'(wr_ready), 32'((cyc % (MAX_WAIT + 1)) == MAX_WAIT));
`else
                check("no_guard_grant", 32'(wr_ready), 32'd0);
`endif
            end
            if (mode == 4 && cyc == 31) begin
                @(negedge clk);
                #1;
                check("rst_valid", 32'(rd_valid), 32'd0);
                check("rst_addr", 32'(rd_addr), 32'd0);
                check("rst_data", 32'(rd_data), 32'd0);
                check("rst_last", 32'(rd_last), 32'd0);
                check("rst_busy", 32'(scan_busy), 32'd0);
                check("rst_done", 32'(scan_done), 32'd0);
                check("rst_overrun", 32'(overrun), 32'd0);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    check("post_rst_valid", 32'(rd_valid), 32'd0);
                    check("post_rst_busy", 32'(scan_busy), 32'd0);
                end
                return;
            end
        end
        check("beat_count", 32'(beat), 32'(DEPTH));
        if (mode == 1) check("stall_grants_seen", 32'(grants > 0), 32'd1);
        @(negedge clk);
        frame_start = 1'b0;
        rd_ready    = 1'b1;
        if (mode != 5) wr_valid = 1'b0;
        #1;
        check("end_busy", 32'(scan_busy), 32'd0);
        check("end_valid", 32'(rd_valid), 32'd0);
        if (mode == 3) check("overrun_set", 32'(overrun), 32'd1);
        if (mode == 5) check("idle_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_ready    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 16'(16'h1000 + i * 16'h0101);
            exp_mem[i] = 16'(16'h1000 + i * 16'h0101);
        end

        @(negedge clk);
        #1;
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_addr", 32'(rd_addr), 32'd0);
        check("reset_data", 32'(rd_data), 32'd0);
        check("reset_last", 32'(rd_last), 32'd0);
        check("reset_busy", 32'(scan_busy), 32'd0);
        check("reset_done", 32'(scan_done), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_ram_we", 32'(ram_we), 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 6'd5;
        wr_data  = 16'hBEEF;
        exp_mem[5] = 16'hBEEF;
        #1;
        check("idle_wr_ready", 32'(wr_ready), 32'd1);
        check("idle_ram_we", 32'(ram_we), 32'd1);
        check("idle_ram_addr", 32'(ram_addr), 32'd5);
        check("idle_ram_din", 32'(ram_din), 32'hBEEF);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("idle_we_low", 32'(ram_we), 32'd0);

        run_scan(0);
        run_scan(1);
        run_scan(2);
        run_scan(3);
        run_scan(4);
        run_scan(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
